seq_scan_ctrl: RTL and testbench



---
 rtl/seq_scan_pkg.sv | 18 +
 rtl/seq_scan_ctrl_if.sv | 39 +++
 rtl/seq_match_core.sv | 48 ++++
 rtl/seq_scan_ctrl.sv | 114 +++++++++++
 tb/tb_seq_scan_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_scan_pkg.sv
// Shared types and helpers for the sequence scan controller.
// Holds the FSM state encoding and the pattern-length counter width derivation.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_MAX_LEN = 8;

  // Width that can hold every length 0..max_len.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Configuration, stream and status bundle of seq_scan_ctrl.
// The master drives configuration and stream; the slave is the controller.
interface seq_scan_ctrl_if
  import seq_scan_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int WIN_W   = 16,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = len_w(MAX_LEN)
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [WIN_W-1:0]   cfg_window;
  logic               cfg_err;
  logic               start;
  logic               abort;
  logic               x_valid;
  logic               x;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               busy;
  logic               done;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_window,
    output start, abort, x_valid, x,
    input  cfg_ready, cfg_err, match, match_count, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_window,
    input  start, abort, x_valid, x,
    output cfg_ready, cfg_err, match, match_count, busy, done
  );

endinterface

// File: rtl/seq_match_core.sv
// Shift-register pattern matcher: history, fill counter and length-masked compare.
// hit is combinational on the post-shift history, valid only while shift_en is high.
module seq_match_core
  import seq_scan_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               x,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic               overlap,
  output logic               hit
);

  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] w_hist_next;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W-1:0]   w_fill_next;

  assign w_hist_next = {r_hist[MAX_LEN-2:0], x};
  assign w_fill_next = (r_fill >= len) ? len : r_fill + LEN_W'(1);
  // Shifting all-ones left by len leaves exactly the unused upper bits set.
  assign w_mask      = ~({MAX_LEN{1'b1}} << len);

  assign hit = shift_en && (len != '0) && (w_fill_next >= len) &&
               (((w_hist_next ^ pattern) & w_mask) == '0);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (shift_en) begin
      r_hist <= w_hist_next;
      r_fill <= (hit && !overlap) ? '0 : w_fill_next;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Run controller: captures a pattern config, scans a window of valid bits,
// pulses match per hit, keeps a saturating hit count and signals done.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int WIN_W   = 16,
  parameter int CNT_W   = 8
) (
  input logic             clk,
  input logic             rst,
  seq_scan_ctrl_if.slave  bus
);

  localparam int LEN_W = len_w(MAX_LEN);

  state_e             r_state;
  state_e             w_state_next;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [WIN_W-1:0]   r_window;
  logic [WIN_W-1:0]   r_rem;
  logic               r_match;
  logic               r_cfg_err;
  logic [CNT_W-1:0]   r_count;

  logic               w_idle;
  logic               w_cfg_legal;
  logic               w_start;
  logic               w_accept;
  logic               w_last;
  logic               w_hit;
  logic [WIN_W-1:0]   w_start_window;

  assign w_idle         = (r_state == IDLE);
  assign w_cfg_legal    = bus.cfg_valid && (bus.cfg_len != '0) &&
                          (bus.cfg_len <= LEN_W'(MAX_LEN));
  assign w_start        = w_idle && bus.start;
  // A legal config offered with start takes effect for that same run.
  assign w_start_window = w_cfg_legal ? bus.cfg_window : r_window;
  assign w_accept       = (r_state == RUN) && bus.x_valid && !bus.abort;
  assign w_last         = w_accept && (r_rem == WIN_W'(1));

  seq_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_start),
    .shift_en (w_accept),
    .x        (bus.x),
    .len      (r_len),
    .pattern  (r_pattern),
    .overlap  (r_overlap),
    .hit      (w_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (bus.start) w_state_next = (w_start_window == '0) ? DONE : RUN;
      RUN: begin
        if (bus.abort)   w_state_next = IDLE;
        else if (w_last) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.cfg_ready   = (r_state == IDLE);
    bus.busy        = (r_state == RUN);
    bus.done        = (r_state == DONE) && !bus.abort;
    bus.match       = r_match;
    bus.match_count = r_count;
    bus.cfg_err     = r_cfg_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pattern <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_window  <= '0;
      r_rem     <= '0;
      r_match   <= 1'b0;
      r_cfg_err <= 1'b0;
      r_count   <= '0;
    end else begin
      r_cfg_err <= w_idle && bus.cfg_valid && !w_cfg_legal;
      r_match   <= w_hit;
      if (w_idle && w_cfg_legal) begin
        r_pattern <= bus.cfg_pattern;
        r_len     <= bus.cfg_len;
        r_overlap <= bus.cfg_overlap;
        r_window  <= bus.cfg_window;
      end
      if (w_start)       r_rem <= w_start_window;
      else if (w_accept) r_rem <= r_rem - WIN_W'(1);
      if (w_start)                     r_count <= '0;
      else if (w_hit && r_count != '1) r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: directed scenarios plus random runs
// compared cycle by cycle against a bit-list reference model.
module tb_seq_scan_ctrl;

  localparam int MAX_LEN = 8;
  localparam int WIN_W   = 16;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_scan_ctrl_if #(.MAX_LEN(MAX_LEN), .WIN_W(WIN_W), .CNT_W(CNT_W)) bus ();
  seq_scan_ctrl_if #(.MAX_LEN(MAX_LEN), .WIN_W(WIN_W), .CNT_W(2))     sbus ();

  seq_scan_ctrl #(.MAX_LEN(MAX_LEN), .WIN_W(WIN_W), .CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  seq_scan_ctrl #(.MAX_LEN(MAX_LEN), .WIN_W(WIN_W), .CNT_W(2)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cycles;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: whole-run list of accepted bits and a count of fresh bits.
  bit               m_run, m_done, m_match, m_err;
  int               m_count, m_rem, m_fresh;
  bit               m_bits[$];
  logic [MAX_LEN-1:0] c_pat;
  int               c_len, c_win;
  bit               c_ovl;

  task automatic model_reset();
    m_run = 0; m_done = 0; m_match = 0; m_err = 0;
    m_count = 0; m_rem = 0; m_fresh = 0; m_bits.delete();
    c_pat = '0; c_len = 0; c_win = 0; c_ovl = 0;
  endtask

  function automatic bit tail_matches();
    int n = m_bits.size();
    for (int k = 0; k < c_len; k++)
      if (m_bits[n-1-k] != c_pat[k]) return 0;
    return 1;
  endfunction

  task automatic model_step(input bit cv, input logic [MAX_LEN-1:0] cp, input int cl,
                            input bit co, input int cw, input bit st, input bit ab,
                            input bit xv, input bit xb);
    bit legal;
    m_match = 0;
    m_err   = 0;
    if (m_run) begin
      if (ab) m_run = 0;
      else if (xv) begin
        m_bits.push_back(xb);
        m_fresh++;
        if (m_fresh >= c_len && tail_matches()) begin
          m_match = 1;
          if (m_count < CNT_MAX) m_count++;
          if (!c_ovl) m_fresh = 0;
        end
        m_rem--;
        if (m_rem == 0) begin m_run = 0; m_done = 1; end
      end
    end else if (m_done) begin
      m_done = 0;
    end else begin
      legal = cv && cl >= 1 && cl <= MAX_LEN;
      if (cv && !legal) m_err = 1;
      if (legal) begin c_pat = cp; c_len = cl; c_ovl = co; c_win = cw; end
      if (st) begin
        m_count = 0; m_bits.delete(); m_fresh = 0; m_rem = c_win;
        if (c_win == 0) m_done = 1;
        else            m_run  = 1;
      end
    end
  endtask

  task automatic check_outputs();
    check("match",       bus.match,       m_match);
    check("match_count", bus.match_count, m_count);
    check("busy",        bus.busy,        m_run);
    check("done",        bus.done,        m_done);
    check("cfg_ready",   bus.cfg_ready,   !m_run && !m_done);
    check("cfg_err",     bus.cfg_err,     m_err);
    if (bus.busy) busy_cycles++;
  endtask

  task automatic tick(input bit cv, input logic [MAX_LEN-1:0] cp, input int cl, input bit co,
                      input int cw, input bit st, input bit ab, input bit xv, input bit xb);
    bus.cfg_valid   = cv;
    bus.cfg_pattern = cp;
    bus.cfg_len     = cl[LEN_W-1:0];
    bus.cfg_overlap = co;
    bus.cfg_window  = cw[WIN_W-1:0];
    bus.start       = st;
    bus.abort       = ab;
    bus.x_valid     = xv;
    bus.x           = xb;
    @(posedge clk);
    model_step(cv, cp, cl, co, cw, st, ab, xv, xb);
    #1;
    bus.cfg_valid = 0; bus.start = 0; bus.abort = 0; bus.x_valid = 0;
    #1;
    check_outputs();
  endtask

  task automatic cfg(input logic [MAX_LEN-1:0] p, input int l, input bit o, input int w);
    tick(1, p, l, o, w, 0, 0, 0, 0);
  endtask
  task automatic start_run();
    tick(0, '0, 0, 0, 0, 1, 0, 0, 0);
  endtask
  task automatic idle_cycle();
    tick(0, '0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic send_bit(input bit b);
    tick(0, '0, 0, 0, 0, 0, 0, 1, b);
  endtask

  // Bits go out MSB first; gaps inserts an x_valid-low cycle before each bit.
  task automatic stream(input logic [31:0] bits, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) idle_cycle();
      send_bit(bits[n-1-i]);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.cfg_valid = 0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 0;
    bus.cfg_window = '0; bus.start = 0; bus.abort = 0; bus.x_valid = 0; bus.x = 0;
    sbus.cfg_valid = 0; sbus.cfg_pattern = '0; sbus.cfg_len = '0; sbus.cfg_overlap = 0;
    sbus.cfg_window = '0; sbus.start = 0; sbus.abort = 0; sbus.x_valid = 0; sbus.x = 0;
    busy_cycles = 0;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Overlapping 0111 over ten bits.
    cfg(8'b0111, 4, 1, 10);
    start_run();
    stream(32'b0111110111, 10, 0);
    check("s1_count", bus.match_count, 2);
    check("s1_done_with_match", {bus.done, bus.match}, 2'b11);
    idle_cycle();

    // 1011 overlapping then non-overlapping.
    cfg(8'b1011, 4, 1, 7);
    start_run();
    stream(32'b1011011, 7, 0);
    check("s2_ovl_count", bus.match_count, 2);
    idle_cycle();
    cfg(8'b1011, 4, 0, 7);
    start_run();
    stream(32'b1011011, 7, 0);
    check("s2_novl_count", bus.match_count, 1);
    idle_cycle();

    // First scenario with a bubble before every bit.
    cfg(8'b0111, 4, 1, 10);
    busy_cycles = 0;
    start_run();
    stream(32'b0111110111, 10, 1);
    check("s3_count", bus.match_count, 2);
    check("s3_busy_cycles", busy_cycles, 20);
    idle_cycle();

    // Illegal lengths keep the last legal config; zero window finishes at once.
    cfg(8'hFF, 0, 1, 3);
    cfg(8'hFF, 9, 1, 3);
    idle_cycle();
    start_run();
    stream(32'b0111110111, 10, 0);
    check("s4_old_cfg_count", bus.match_count, 2);
    idle_cycle();
    tick(1, 8'hFF, 9, 0, 5, 1, 0, 0, 0);
    stream(32'b0111110111, 10, 0);
    idle_cycle();
    cfg(8'b1, 1, 1, 0);
    start_run();
    check("s4_zero_win_done", bus.done, 1);
    idle_cycle();

    // Abort after bit 5 of the first scenario.
    cfg(8'b0111, 4, 1, 10);
    start_run();
    stream(32'b01111, 5, 0);
    tick(0, '0, 0, 0, 0, 0, 1, 1, 1);
    check("s5_abort_count", bus.match_count, 1);
    idle_cycle();
    tick(0, '0, 0, 0, 0, 0, 1, 0, 0);

    // Asynchronous reset mid-run.
    start_run();
    stream(32'b011, 3, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_cfg_ready", bus.cfg_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_count", bus.match_count, 0);
    @(negedge clk);
    rst = 1'b0;

    // Random runs against the model.
    for (int r = 0; r < 40; r++) begin
      int l, w, guard;
      logic [MAX_LEN-1:0] p;
      l = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 9)
                                      : $urandom_range(1, MAX_LEN);
      w = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 40);
      p = MAX_LEN'($urandom);
      if (r == 0 || $urandom_range(0, 1) == 0) begin
        cfg(p, (r == 0) ? 3 : l, $urandom_range(0, 1), w);
        start_run();
      end else begin
        tick(1, p, l, $urandom_range(0, 1), w, 1, $urandom_range(0, 7) == 0, 0, 0);
      end
      guard = 0;
      while ((m_run || m_done) && guard < 200) begin
        tick(0, '0, 0, 0, 0, $urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 1));
        guard++;
      end
      check("rand_run_ends", guard < 200, 1);
    end

    // Saturation with a 2-bit counter on the second instance.
    @(negedge clk);
    sbus.cfg_valid = 1; sbus.cfg_pattern = 8'h01; sbus.cfg_len = 4'd1;
    sbus.cfg_overlap = 0; sbus.cfg_window = 16'd6;
    @(posedge clk); #1;
    sbus.cfg_valid = 0; sbus.start = 1;
    @(posedge clk); #1;
    sbus.start = 0;
    for (int i = 0; i < 6; i++) begin
      sbus.x_valid = 1; sbus.x = 1;
      @(posedge clk); #1;
      sbus.x_valid = 0;
      #1;
      check("sat_match", sbus.match, 1);
      check("sat_count", sbus.match_count, (i + 1 > 3) ? 3 : i + 1);
      check("sat_done", sbus.done, i == 5);
    end
    @(posedge clk); #1;
    check("sat_idle", sbus.cfg_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
